qc_ldpc_bf_decoder: RTL and testbench

Hard-decision, bit-flipping QC-LDPC decoder: the receive-side counterpart of `qc_ldpc_encoder`. It accepts one full codeword of `TOTAL_BLKS` circulant blocks and iteratively recomputes syndromes against the quasi-cyclic parity-check base matrix. It flips the bits that fail too many checks and returns the corrected information blocks with a pass/fail flag. It sits between the demodulator hard-slicer and the MAC receive buffer.

---
 rtl/qc_ldpc_bf_decoder.sv | 171 +++++++++++++++++
 tb/tb_qc_ldpc_bf_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/qc_ldpc_bf_decoder.sv
// Bit-flipping QC-LDPC decoder; latency k*(P+1+T)+P+1 cycles, DONE holds while out_ready=0.
// Early exit on zero syndrome when QC_LDPC_DEC_EARLY_TERM_EN is defined, else fixed MAX_ITER iterations.
module qc_ldpc_bf_decoder #(
   parameter int Z               = 54,
   parameter int NUM_INFO_BLKS   = 20,
   parameter int NUM_PARITY_BLKS = 4,
   parameter int TOTAL_BLKS      = NUM_INFO_BLKS + NUM_PARITY_BLKS,
   parameter int H_SHIFT [NUM_PARITY_BLKS][TOTAL_BLKS] = '{default: '{default: -1}},
   parameter int MAX_ITER        = 8,
   parameter int FLIP_THRESH     = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [TOTAL_BLKS-1:0][Z-1:0]           cw_in,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [NUM_INFO_BLKS-1:0][Z-1:0]        info_out,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic                                   dec_ok,
   output logic [$clog2(MAX_ITER+1)-1:0]          iter_count
);
   localparam int P  = NUM_PARITY_BLKS;
   localparam int T  = TOTAL_BLKS;
   localparam int IW = $clog2(MAX_ITER+1);
   localparam int RW = (P > 1) ? $clog2(P) : 1;
   localparam int CW = (T > 1) ? $clog2(T) : 1;

   function automatic bit h_valid();
      bit any;
      for (int r = 0; r < P; r++) begin
         any = 1'b0;
         for (int c = 0; c < T; c++) begin
            if (H_SHIFT[r][c] < -1 || H_SHIFT[r][c] >= Z) return 1'b0;
            if (H_SHIFT[r][c] != -1) any = 1'b1;
         end
         if (!any) return 1'b0;
      end
      return 1'b1;
   endfunction

   if (!h_valid()) begin : g_bad_h
      $error("qc_ldpc_bf_decoder: H_SHIFT entry out of range or row with no circulant");
   end
   if (MAX_ITER < 1 || FLIP_THRESH < 1) begin : g_bad_cfg
      $error("qc_ldpc_bf_decoder: MAX_ITER and FLIP_THRESH must be at least 1");
   end

   function automatic logic [Z-1:0] rotl(input logic [Z-1:0] v, input int s);
      logic [2*Z-1:0] d;
      d = {v, v} << s;
      return d[2*Z-1:Z];
   endfunction

   typedef enum logic [2:0] {IDLE, SYND, CHECK, FLIP, DONE} state_t;
   state_t state_q, state_d;

   logic [T-1:0][Z-1:0] cw_q;
   logic [P-1:0][Z-1:0] syn_q;
   logic [IW-1:0]       iter_q;
   logic [RW-1:0]       row_q;
   logic [CW-1:0]       col_q;
   logic [Z-1:0]        syn_row, flip_col, rot;
   int                  cnt [Z];
   logic                syn_ok, iter_max, chk_exit, last_row, last_col;

   assign syn_ok   = ~|syn_q;
   assign iter_max = (iter_q == IW'(MAX_ITER));
   assign last_row = (row_q == RW'(P-1));
   assign last_col = (col_q == CW'(T-1));
`ifdef QC_LDPC_DEC_EARLY_TERM_EN
   assign chk_exit = syn_ok || iter_max;
`else
   assign chk_exit = iter_max;
`endif

   always_comb begin
      syn_row = '0;
      for (int r = 0; r < P; r++)
         if (r == int'(row_q))
            for (int c = 0; c < T; c++)
               if (H_SHIFT[r][c] >= 0) syn_row = syn_row ^ rotl(cw_q[c], H_SHIFT[r][c]);
   end

   // Right-rotating syn[r] by the shift lines check bit (b+s) mod Z up with bit b of the column.
   always_comb begin
      flip_col = '0;
      rot      = '0;
      for (int b = 0; b < Z; b++) cnt[b] = 0;
      for (int c = 0; c < T; c++) begin
         if (c == int'(col_q)) begin
            for (int r = 0; r < P; r++) begin
               if (H_SHIFT[r][c] >= 0) begin
                  rot = rotl(syn_q[r], (Z - H_SHIFT[r][c]) % Z);
                  for (int b = 0; b < Z; b++)
                     if (rot[b]) cnt[b] = cnt[b] + 1;
               end
            end
            for (int b = 0; b < Z; b++)
               flip_col[b] = cw_q[c][b] ^ (cnt[b] >= FLIP_THRESH);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = SYND;
         end
         SYND:  if (last_row) state_d = CHECK;
         CHECK: state_d = chk_exit ? DONE : FLIP;
         FLIP:  if (last_col) state_d = SYND;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw_q       <= '0;
         syn_q      <= '0;
         iter_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         info_out   <= '0;
         dec_ok     <= 1'b0;
         iter_count <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               cw_q   <= cw_in;
               iter_q <= '0;
               row_q  <= '0;
            end
            SYND: begin
               syn_q[row_q] <= syn_row;
               row_q        <= row_q + RW'(1);
            end
            CHECK: begin
               col_q <= '0;
               if (chk_exit) begin
                  info_out   <= cw_q[NUM_INFO_BLKS-1:0];
                  dec_ok     <= syn_ok;
                  iter_count <= iter_q;
               end
            end
            FLIP: begin
               cw_q[col_q] <= flip_col;
               col_q       <= col_q + CW'(1);
               if (last_col) begin
                  iter_q <= iter_q + IW'(1);
                  row_q  <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_qc_ldpc_bf_decoder.sv
// Bench for qc_ldpc_bf_decoder: directed vector table, handshake/reset sequences, random codewords vs a reference model.
module tb_qc_ldpc_bf_decoder;
   localparam int Z = 4, NI = 2, NP = 2, T = 4, MAXI = 3, FT = 2;
   localparam int H [NP][T] = '{'{0, 1, 0, -1}, '{2, -1, -1, 0}};
`ifdef QC_LDPC_DEC_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic                  clk, rst;
   logic [T-1:0][Z-1:0]   cw_in;
   logic                  in_valid, in_ready, out_valid, out_ready, dec_ok;
   logic [NI-1:0][Z-1:0]  info_out;
   logic [1:0]            iter_count;

   int n_tests = 0;
   int n_fail  = 0;

   qc_ldpc_bf_decoder #(
      .Z(Z), .NUM_INFO_BLKS(NI), .NUM_PARITY_BLKS(NP), .TOTAL_BLKS(T),
      .H_SHIFT(H), .MAX_ITER(MAXI), .FLIP_THRESH(FT)
   ) dut (
      .clk(clk), .rst(rst), .cw_in(cw_in), .in_valid(in_valid), .in_ready(in_ready),
      .info_out(info_out), .out_valid(out_valid), .out_ready(out_ready),
      .dec_ok(dec_ok), .iter_count(iter_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: parity checks evaluated bit by bit straight from the rotation definition.
   function automatic void model(input logic [15:0] cw, output logic [7:0] info,
                                 output bit ok, output int iters, output int lat);
      bit b [T][Z];
      bit s [NP][Z];
      int cnt;
      for (int c = 0; c < T; c++)
         for (int i = 0; i < Z; i++) b[c][i] = cw[c*Z+i];
      iters = 0;
      while (1) begin
         ok = 1'b1;
         for (int r = 0; r < NP; r++)
            for (int i = 0; i < Z; i++) begin
               s[r][i] = 1'b0;
               for (int c = 0; c < T; c++)
                  if (H[r][c] >= 0) s[r][i] ^= b[c][(i - H[r][c] + Z) % Z];
               if (s[r][i]) ok = 1'b0;
            end
         if ((EARLY && ok) || iters == MAXI) break;
         for (int c = 0; c < T; c++)
            for (int i = 0; i < Z; i++) begin
               cnt = 0;
               for (int r = 0; r < NP; r++)
                  if (H[r][c] >= 0) cnt += int'(s[r][(i + H[r][c]) % Z]);
               if (cnt >= FT) b[c][i] = ~b[c][i];
            end
         iters++;
      end
      lat = iters * (NP + 1 + T) + NP + 1;
      for (int c = 0; c < NI; c++)
         for (int i = 0; i < Z; i++) info[c*Z+i] = b[c][i];
   endfunction

   task automatic start_dec(input logic [15:0] cw);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
      cw_in = cw;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_dec(input logic [15:0] cw, output logic [7:0] info,
                          output bit ok, output int it, output int lat);
      start_dec(cw);
      lat = 0;
      while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
      info = info_out;
      ok   = dec_ok;
      it   = int'(iter_count);
   endtask

   task automatic release_out();
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("in_ready_after_hs", in_ready, 1);
      chk("out_valid_after_hs", out_valid, 0);
   endtask

   task automatic check_case(input string nm, input logic [15:0] cw, input logic [7:0] e_info,
                             input bit e_ok, input int e_it, input int e_lat);
      logic [7:0] info; bit ok; int it, lat;
      run_dec(cw, info, ok, it, lat);
      chk({nm, "_lat"},  lat,  e_lat);
      chk({nm, "_info"}, info, e_info);
      chk({nm, "_ok"},   ok,   e_ok);
      chk({nm, "_iter"}, it,   e_it);
      release_out();
   endtask

   typedef struct {
      logic [15:0] cw;
      logic [7:0]  info;
      bit          ok;
      int          iters;
      int          lat;
   } vec_t;

   initial begin
      vec_t tv [4];
      logic [7:0] m_info; bit m_ok; int m_it, m_lat;
      logic [15:0] rcw;

      tv[0] = '{16'h0000, 8'h00, 1'b1, EARLY ? 0 : 3, EARLY ? 3  : 24};
      tv[1] = '{16'h0001, 8'h00, 1'b1, EARLY ? 1 : 3, EARLY ? 10 : 24};
      tv[2] = '{16'h0010, 8'h10, 1'b0, 3,             24};
      tv[3] = '{16'h0002, 8'h00, 1'b1, EARLY ? 1 : 3, EARLY ? 10 : 24};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cw_in = '0;
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_info", info_out, 0);
      chk("rst_dec_ok", dec_ok, 0);
      chk("rst_iter", iter_count, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("post_rst_in_ready", in_ready, 1);

      for (int i = 0; i < 4; i++)
         check_case($sformatf("vec%0d", i), tv[i].cw, tv[i].info, tv[i].ok, tv[i].iters, tv[i].lat);

      // Back-pressure: DONE must hold and ignore new input.
      model(16'h0001, m_info, m_ok, m_it, m_lat);
      run_dec(16'h0001, m_info, m_ok, m_it, m_lat);
      model(16'h0001, m_info, m_ok, m_it, m_lat);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         cw_in = 16'hffff;
         @(posedge clk);
         #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_info", info_out, m_info);
         chk("bp_ok", dec_ok, m_ok);
         chk("bp_iter", iter_count, m_it);
      end
      @(negedge clk) in_valid = 1'b0;
      release_out();
      repeat (2) @(posedge clk);
      #1 chk("bp_idle_stays", out_valid, 0);

      // Reset in the middle of FLIP after a failing decode left non-zero outputs.
      check_case("pre_rst", 16'h0010, 8'h10, 1'b0, 3, 24);
      start_dec(16'h0010);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_info", info_out, 0);
      chk("mid_rst_ok", dec_ok, 0);
      chk("mid_rst_iter", iter_count, 0);
      @(negedge clk) rst = 1'b0;
      model(16'h0001, m_info, m_ok, m_it, m_lat);
      check_case("after_rst", 16'h0001, m_info, m_ok, m_it, m_lat);

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 2))
            0:       rcw = 16'($urandom);
            1:       rcw = 16'h1 << $urandom_range(0, 15);
            default: rcw = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
         endcase
         model(rcw, m_info, m_ok, m_it, m_lat);
         check_case($sformatf("rnd%0d_%04h", n, rcw), rcw, m_info, m_ok, m_it, m_lat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
